// File: rtl/start_pulse_scheduler.sv
// start_pulse_scheduler: shares one compute engine between N_REQ level-triggered
// requesters. It captures rising edges as pending requests, grants round-robin with
// a one-cycle start pulse plus the requester ID, and returns a one-hot done pulse.
// Optional watchdog: define START_SCHED_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles, pulsing timeout_err.
module start_pulse_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = $clog2(N_REQ),
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req_level,
  output logic             eng_start,
  output logic [ID_W-1:0]  eng_id,
  input  logic             eng_done,
  output logic [N_REQ-1:0] req_done,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(N_REQ - 1);

  // Reject parameter sets the arbiter cannot handle.
  if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("start_pulse_scheduler: need N_REQ >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [N_REQ-1:0]  level_q;
  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  grant_mask;
  logic [N_REQ-1:0]  done_d;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   last_grant_d;
  logic [ID_W-1:0]   id_d;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              start_d;
  logic              done_accept;
  logic              timeout_hit;

  assign rise = req_level & ~level_q;

  // A done pulse counts only once the start pulse has dropped.
  assign done_accept = (state == WAIT) && eng_done && !eng_start;

  // Round-robin search: first pending bit after last_grant, wrapping.
  always_comb begin : rr_search
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((32'(last_grant) + i) % N_REQ);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin : fsm_state
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state and registered-output next values.
  always_comb begin : fsm_next
    state_d      = state;
    start_d      = 1'b0;
    id_d         = eng_id;
    grant_mask   = '0;
    done_d       = '0;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (found) begin
          start_d    = 1'b1;
          id_d       = winner;
          grant_mask = N_REQ'(1) << winner;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (done_accept) begin
          done_d       = N_REQ'(1) << eng_id;
          last_grant_d = eng_id;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          last_grant_d = eng_id;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge capture, pending set/clear (set wins), and registered outputs.
  always_ff @(posedge clk) begin : datapath
    if (!rstn) begin
      level_q    <= '0;
      pending    <= '0;
      last_grant <= LAST_GRANT_RST;
      eng_start  <= 1'b0;
      eng_id     <= '0;
      req_done   <= '0;
      busy       <= 1'b0;
    end else begin
      level_q    <= req_level;
      pending    <= (pending & ~grant_mask) | rise;
      last_grant <= last_grant_d;
      eng_start  <= start_d;
      eng_id     <= id_d;
      req_done   <= done_d;
      busy       <= (state_d == WAIT);
    end
  end

`ifdef START_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counter would reach TIMEOUT_CYC on this edge; a same-edge done wins.
  assign timeout_hit = (state == WAIT) && (wd_cnt == WD_LAST) && !done_accept;

  // Watchdog counter and timeout pulse.
  always_ff @(posedge clk) begin : watchdog
    if (!rstn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (start_d) begin
        wd_cnt <= '0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_start_pulse_scheduler.sv
// Directed testbench for start_pulse_scheduler (N_REQ=4, TIMEOUT_CYC=8).
module tb_start_pulse_scheduler;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned ID_W        = 2;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N_REQ-1:0] req_level;
  logic             eng_start;
  logic [ID_W-1:0]  eng_id;
  logic             eng_done;
  logic [N_REQ-1:0] req_done;
  logic [N_REQ-1:0] pending;
  logic             busy;
  logic             timeout_err;

  int errors = 0;
  int checks = 0;

  int          nstart;
  int          ndone;
  logic [31:0] order;

  start_pulse_scheduler #(
    .N_REQ      (N_REQ),
    .ID_W       (ID_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_level  (req_level),
    .eng_start  (eng_start),
    .eng_id     (eng_id),
    .eng_done   (eng_done),
    .req_done   (req_done),
    .pending    (pending),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next active edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: completes each start lat cycles later; logs grant order.
  task automatic run(input int ncyc, input int lat, output int ns, output int nd,
                     output logic [31:0] ord);
    int cd;
    cd  = 0;
    ns  = 0;
    nd  = 0;
    ord = '0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      eng_done = 1'b0;
      if (eng_start) begin
        ns++;
        ord = {ord[27:0], 2'b00, eng_id};
        cd  = lat - 1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) eng_done = 1'b1;
      end
      if (req_done != '0) nd++;
    end
    eng_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn      = 1'b0;
    req_level = '0;
    eng_done  = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_start",   32'(eng_start),   32'h0);
    check_eq("rst_id",      32'(eng_id),      32'h0);
    check_eq("rst_done",    32'(req_done),    32'h0);
    check_eq("rst_pending", 32'(pending),     32'h0);
    check_eq("rst_busy",    32'(busy),        32'h0);
    check_eq("rst_tmo",     32'(timeout_err), 32'h0);
    rstn = 1'b1;
    tick();

    // 1: single request on requester 2, done sampled 6 edges after start
    req_level = 4'b0100;
    tick();
    check_eq("t1_pend_k",   32'(pending),   32'h4);
    check_eq("t1_start_k",  32'(eng_start), 32'h0);
    tick();
    check_eq("t1_start",    32'(eng_start), 32'h1);
    check_eq("t1_id",       32'(eng_id),    32'h2);
    check_eq("t1_pend_s",   32'(pending),   32'h0);
    check_eq("t1_busy_s",   32'(busy),      32'h1);
    req_level = 4'b0000;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_eq("t1_start_lo", 32'(eng_start), 32'h0);
      check_eq("t1_busy",     32'(busy),      32'h1);
      check_eq("t1_nodone",   32'(req_done),  32'h0);
    end
    eng_done = 1'b1;
    tick();
    check_eq("t1_req_done", 32'(req_done), 32'h4);
    check_eq("t1_busy_end", 32'(busy),     32'h0);
    eng_done = 1'b0;
    tick();
    check_eq("t1_done_1cy", 32'(req_done), 32'h0);
    check_eq("t1_id_hold",  32'(eng_id),   32'h2);

    // 2: level held 30 cycles gives one service only
    req_level = 4'b0001;
    run(30, 3, nstart, ndone, order);
    check_eq("t2_starts_a", 32'(nstart), 32'd1);
    check_eq("t2_dones_a",  32'(ndone),  32'd1);
    req_level = 4'b0000;
    run(10, 3, nstart, ndone, order);
    check_eq("t2_starts_b", 32'(nstart), 32'd0);
    check_eq("t2_dones_b",  32'(ndone),  32'd0);

    // 3: fairness; levels high through reset release
    rstn      = 1'b0;
    req_level = 4'b1011;
    tick(); tick();
    rstn = 1'b1;
    run(30, 3, nstart, ndone, order);
    check_eq("t3_order_a",  order & 32'hfff, 32'h013);
    check_eq("t3_starts_a", 32'(nstart),     32'd3);
    check_eq("t3_dones_a",  32'(ndone),      32'd3);
    req_level = 4'b0000;
    run(5, 3, nstart, ndone, order);
    req_level = 4'b0010;
    run(15, 3, nstart, ndone, order);
    check_eq("t3_grant1",   order & 32'hf,   32'h1);
    req_level = 4'b0000;
    run(3, 3, nstart, ndone, order);
    req_level = 4'b1001;
    run(20, 3, nstart, ndone, order);
    check_eq("t3_order_b",  order & 32'hff,  32'h30);
    check_eq("t3_starts_b", 32'(nstart),     32'd2);
    req_level = 4'b0000;
    run(3, 3, nstart, ndone, order);

    // 4: same-edge set/clear and re-rise during own service
    req_level = 4'b0001;
    tick();
    req_level = 4'b0000;
    tick();
    check_eq("t4_start0",  32'(eng_start), 32'h1);
    check_eq("t4_id0",     32'(eng_id),    32'h0);
    req_level = 4'b0010;
    tick();
    check_eq("t4_pend1",   32'(pending),   32'h2);
    req_level = 4'b0000;
    tick();
    eng_done = 1'b1;
    tick();
    check_eq("t4_done0",   32'(req_done),  32'h1);
    eng_done  = 1'b0;
    req_level = 4'b0010;
    tick();
    check_eq("t4_start1",  32'(eng_start), 32'h1);
    check_eq("t4_id1",     32'(eng_id),    32'h1);
    check_eq("t4_setwins", 32'(pending),   32'h2);
    req_level = 4'b0000;
    tick();
    req_level = 4'b0010;
    tick();
    check_eq("t4_merge",   32'(pending),   32'h2);
    check_eq("t4_busy",    32'(busy),      32'h1);
    req_level = 4'b0000;
    eng_done  = 1'b1;
    tick();
    check_eq("t4_done1a",  32'(req_done),  32'h2);
    eng_done = 1'b0;
    tick();
    check_eq("t4_start1b", 32'(eng_start), 32'h1);
    check_eq("t4_id1b",    32'(eng_id),    32'h1);
    check_eq("t4_pend0",   32'(pending),   32'h0);
    tick();
    eng_done = 1'b1;
    tick();
    check_eq("t4_done1b",  32'(req_done),  32'h2);
    eng_done = 1'b0;
    tick();
    check_eq("t4_idle",    32'(busy),      32'h0);

    // 5: stale done in IDLE and during the start cycle is ignored
    eng_done = 1'b1;
    tick(); tick();
    check_eq("t5_idle_done",  32'(req_done),  32'h0);
    check_eq("t5_idle_busy",  32'(busy),      32'h0);
    check_eq("t5_idle_start", 32'(eng_start), 32'h0);
    eng_done  = 1'b0;
    req_level = 4'b1000;
    tick();
    tick();
    check_eq("t5_start", 32'(eng_start), 32'h1);
    check_eq("t5_id",    32'(eng_id),    32'h3);
    eng_done = 1'b1;
    tick();
    check_eq("t5_ign_done", 32'(req_done), 32'h0);
    check_eq("t5_ign_busy", 32'(busy),     32'h1);
    eng_done  = 1'b0;
    req_level = 4'b0000;
    tick(); tick();
    check_eq("t5_still_busy", 32'(busy),     32'h1);
    check_eq("t5_no_done",    32'(req_done), 32'h0);
    eng_done = 1'b1;
    tick();
    check_eq("t5_done", 32'(req_done), 32'h8);
    eng_done = 1'b0;
    tick();

    // 6: watchdog (when built in) then reset in the middle of WAIT
    req_level = 4'b0100;
    tick();
    req_level = 4'b0000;
    tick();
    check_eq("t6_start", 32'(eng_start), 32'h1);
    check_eq("t6_id",    32'(eng_id),    32'h2);
`ifdef START_SCHED_TIMEOUT_EN
    for (int j = 1; j <= 8; j++) begin
      if (j == 1) req_level = 4'b0001;
      if (j == 2) req_level = 4'b0000;
      tick();
      check_eq("t6_no_done", 32'(req_done), 32'h0);
      if (j < 8) begin
        check_eq("t6_tmo_lo", 32'(timeout_err), 32'h0);
        check_eq("t6_busy",   32'(busy),        32'h1);
      end
    end
    check_eq("t6_tmo",      32'(timeout_err), 32'h1);
    check_eq("t6_tmo_busy", 32'(busy),        32'h0);
    tick();
    check_eq("t6_tmo_1cy",  32'(timeout_err), 32'h0);
    check_eq("t6_next",     32'(eng_start),   32'h1);
    check_eq("t6_next_id",  32'(eng_id),      32'h0);
    check_eq("t6_no_done2", 32'(req_done),    32'h0);
`else
    for (int j = 1; j <= 12; j++) begin
      if (j == 1) req_level = 4'b0001;
      if (j == 2) req_level = 4'b0000;
      tick();
    end
    check_eq("t6_wait_busy", 32'(busy),        32'h1);
    check_eq("t6_tmo_off",   32'(timeout_err), 32'h0);
    check_eq("t6_pend_wait", 32'(pending),     32'h1);
`endif
    req_level = 4'b0010;
    tick();
    req_level = 4'b0000;
    rstn      = 1'b0;
    eng_done  = 1'b1;
    tick();
    check_eq("t6_rst_start", 32'(eng_start),   32'h0);
    check_eq("t6_rst_id",    32'(eng_id),      32'h0);
    check_eq("t6_rst_busy",  32'(busy),        32'h0);
    check_eq("t6_rst_pend",  32'(pending),     32'h0);
    check_eq("t6_rst_done",  32'(req_done),    32'h0);
    check_eq("t6_rst_tmo",   32'(timeout_err), 32'h0);
    rstn = 1'b1;
    tick();
    check_eq("t6_post_done", 32'(req_done), 32'h0);
    check_eq("t6_post_busy", 32'(busy),     32'h0);
    eng_done = 1'b0;
    tick();
    check_eq("t6_post_start", 32'(eng_start), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
